pc_predict_unit: RTL and testbench

Parametrised program-counter generator for the out-of-order RISC-V core, sitting between the instruction fetcher and the ROB. It holds the fetch PC, computes the next PC from each fetched instruction, and predicts conditional branches with a configurable table of saturating counters. It also predicts function returns with a return-address stack (RAS). It takes redirects on misprediction and trains the predictor on every branch the ROB resolves, not only on mispredicted ones.

---
 rtl/pc_predict_if.sv | 22 ++
 rtl/pc_predict_unit.sv | 115 +++++++++++
 tb/tb_pc_predict_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pc_predict_if.sv
// pc_predict_if: fetch/ROB-side signals of the PC predictor.
interface pc_predict_if;
  logic        rdy;
  logic        has_ask;
  logic [31:0] inst;
  logic [31:0] out_next_pc;
  logic        pc_ready;
  logic        has_jump;
  logic        has_misbranch;
  logic [31:0] in_true_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  modport master (
    output rdy, has_ask, inst, has_misbranch, in_true_pc, upd_valid, upd_pc, upd_taken,
    input  out_next_pc, pc_ready, has_jump
  );
  modport slave (
    input  rdy, has_ask, inst, has_misbranch, in_true_pc, upd_valid, upd_pc, upd_taken,
    output out_next_pc, pc_ready, has_jump
  );
endinterface

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC generator with a saturating-counter branch predictor and a return-address stack.
module pc_predict_unit #(
  parameter int BHT_IDX_BITS = 8,
  parameter int CTR_BITS     = 2,
  parameter int RAS_DEPTH    = 4
) (
  input logic         clk,
  input logic         rst,
  pc_predict_if.slave bus
);
  localparam int N  = 1 << BHT_IDX_BITS;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [PW:0]         RAS_FULL = (PW+1)'(RAS_DEPTH);
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  logic [31:0]         pc_q, pc_d;
  logic                pc_ready_q, pc_ready_d;
  logic                has_jump_q, has_jump_d;
  logic [CTR_BITS-1:0] ctr_q [N];
  logic [CTR_BITS-1:0] ctr_d [N];
  logic [31:0]         ras_q [RAS_DEPTH];
  logic [31:0]         ras_d [RAS_DEPTH];
  logic [PW-1:0]       ras_ptr_q, ras_ptr_d, ptr_dec;
  logic [PW:0]         ras_cnt_q, ras_cnt_d;
  logic [31:0]         inst, b_imm, j_imm, pc_seq;
  logic [4:0]          rd, rs1;
  logic [BHT_IDX_BITS-1:0] f_idx, u_idx;
  logic [CTR_BITS-1:0] u_ctr;
  logic                is_b, is_jal, is_ret, link, pred_taken;
  logic                unused_upd_bits;
  assign inst            = bus.inst;
  assign rd              = inst[11:7];
  assign rs1             = inst[19:15];
  assign b_imm           = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign j_imm           = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_seq          = pc_q + 32'd4;
  assign is_b            = inst[6:0] == OP_B;
  assign is_jal          = inst[6:0] == OP_JAL;
  assign link            = rd == 5'd1 || rd == 5'd5;
  assign is_ret          = inst[6:0] == OP_JALR && rd == 5'd0 && (rs1 == 5'd1 || rs1 == 5'd5);
  assign f_idx           = pc_q[BHT_IDX_BITS+1:2];
  assign u_idx           = bus.upd_pc[BHT_IDX_BITS+1:2];
  assign pred_taken      = ctr_q[f_idx][CTR_BITS-1];
  assign u_ctr           = ctr_q[u_idx];
  assign ptr_dec         = ras_ptr_q - 1'b1;
  assign unused_upd_bits = ^{bus.upd_pc[31:BHT_IDX_BITS+2], bus.upd_pc[1:0]};
  assign bus.out_next_pc = pc_q;
  assign bus.pc_ready    = pc_ready_q;
  assign bus.has_jump    = has_jump_q;
  always_comb begin
    pc_d       = pc_q;
    pc_ready_d = pc_ready_q;
    has_jump_d = has_jump_q;
    ctr_d      = ctr_q;
    ras_d      = ras_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    if (bus.has_misbranch) begin
      pc_d       = bus.in_true_pc;
      pc_ready_d = 1'b1;
      has_jump_d = 1'b0;
      ras_cnt_d  = '0;
    end else if (bus.rdy) begin
      pc_ready_d = bus.has_ask;
      if (bus.has_ask) begin
        pc_d       = pc_seq;
        has_jump_d = 1'b0;
        if (is_b && pred_taken) begin
          pc_d       = pc_q + b_imm;
          has_jump_d = 1'b1;
        end else if (is_jal) begin
          pc_d       = pc_q + j_imm;
          has_jump_d = 1'b1;
          if (link) begin
            // a push onto a full stack silently overwrites the oldest slot
            ras_d[ras_ptr_q] = pc_seq;
            ras_ptr_d        = ras_ptr_q + 1'b1;
            ras_cnt_d        = ras_cnt_q == RAS_FULL ? ras_cnt_q : ras_cnt_q + 1'b1;
          end
        end else if (is_ret && ras_cnt_q != '0) begin
          pc_d       = ras_q[ptr_dec];
          has_jump_d = 1'b1;
          ras_ptr_d  = ptr_dec;
          ras_cnt_d  = ras_cnt_q - 1'b1;
        end
      end
    end
    // training reads ctr_q, so a same-cycle lookup still sees the old value
    if (bus.upd_valid && (bus.rdy || bus.has_misbranch))
      ctr_d[u_idx] = bus.upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + 1'b1)
                                   : (u_ctr == '0 ? u_ctr : u_ctr - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      pc_ready_q <= 1'b0;
      has_jump_q <= 1'b0;
      ctr_q      <= '{default: CTR_INIT};
      ras_q      <= '{default: '0};
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_ready_q <= pc_ready_d;
      has_jump_q <= has_jump_d;
      ctr_q      <= ctr_d;
      ras_q      <= ras_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: scoreboard bench for pc_predict_unit against a queue-based reference model.
module tb_pc_predict_unit;
  localparam int CHALF = 4;
  localparam int CMAX  = 7;
  typedef struct packed {logic [31:0] pc; logic rdy_o; logic jmp;} exp_t;
  logic clk, rst;
  pc_predict_if bus ();
  pc_predict_unit #(.BHT_IDX_BITS(8), .CTR_BITS(3), .RAS_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t        expq [$];
  int          n_chk, n_pass;
  logic [31:0] m_pc;
  logic        m_pcr, m_jmp;
  int unsigned m_ctr [256];
  logic [31:0] m_ras [$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'd0, rd, 7'b1100111};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask
  task automatic step(input bit r, input bit ry, input bit ask, input logic [31:0] in,
                      input bit mb, input logic [31:0] tp, input bit uv, input logic [31:0] up, input bit ut);
    logic [31:0] nxt, bimm, jimm;
    int ui;
    bit tk;
    @(negedge clk);
    rst = r; bus.rdy = ry; bus.has_ask = ask; bus.inst = in; bus.has_misbranch = mb;
    bus.in_true_pc = tp; bus.upd_valid = uv; bus.upd_pc = up; bus.upd_taken = ut;
    if (r) begin
      m_pc = 0; m_pcr = 0; m_jmp = 0;
      foreach (m_ctr[i]) m_ctr[i] = CHALF;
      m_ras.delete();
    end else begin
      ui   = int'(up[9:2]);
      tk   = m_ctr[int'(m_pc[9:2])] >= CHALF;
      bimm = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
      jimm = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
      if (mb) begin
        m_pc = tp; m_pcr = 1; m_jmp = 0;
        m_ras.delete();
      end else if (ry) begin
        m_pcr = ask;
        if (ask) begin
          nxt = m_pc + 4; m_jmp = 0;
          if (in[6:0] == 7'b1100011 && tk) begin
            nxt = m_pc + bimm; m_jmp = 1;
          end else if (in[6:0] == 7'b1101111) begin
            if (in[11:7] == 1 || in[11:7] == 5) begin
              m_ras.push_back(m_pc + 4);
              if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            nxt = m_pc + jimm; m_jmp = 1;
          end else if (in[6:0] == 7'b1100111 && in[11:7] == 0 && (in[19:15] == 1 || in[19:15] == 5)
                       && m_ras.size() > 0) begin
            nxt = m_ras.pop_back(); m_jmp = 1;
          end
          m_pc = nxt;
        end
      end
      if (uv && (ry || mb))
        m_ctr[ui] = ut ? (m_ctr[ui] < CMAX ? m_ctr[ui] + 1 : CMAX) : (m_ctr[ui] > 0 ? m_ctr[ui] - 1 : 0);
    end
    expq.push_back('{m_pc, m_pcr, m_jmp});
  endtask
  task automatic fetch(input logic [31:0] in);
    step(0, 1, 1, in, 0, 0, 0, 0, 0);
  endtask
  task automatic flush(input logic [31:0] tp);
    step(0, 1, 0, 0, 1, tp, 0, 0, 0);
  endtask
  task automatic upd(input logic [31:0] up, input bit t);
    step(0, 1, 0, 0, 0, 0, 1, up, t);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_next_pc", bus.out_next_pc, e.pc);
        chk("pc_ready", 32'(bus.pc_ready), 32'(e.rdy_o));
        chk("has_jump", 32'(bus.has_jump), 32'(e.jmp));
      end
    end
  end
  initial begin
    logic [31:0] rv, in;
    logic [4:0]  rds [4];
    rds = '{5'd0, 5'd1, 5'd5, 5'd2};
    rst = 1'b1; bus.rdy = 0; bus.has_ask = 0; bus.inst = 0; bus.has_misbranch = 0;
    bus.in_true_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    n_chk = 0; n_pass = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h13, 0, 0, 0, 0, 0);
    fetch(32'h13);
    flush(32'h100);
    fetch(enc_b(13'h1ff8));
    flush(32'h100);
    upd(32'h100, 0);
    upd(32'h100, 0);
    fetch(enc_b(13'h1ff8));
    flush(32'h10);
    repeat (5) fetch(enc_jal(5'd1, 21'h10));
    repeat (5) fetch(enc_jalr(5'd0, 5'd1));
    fetch(enc_jal(5'd5, 21'h100));
    step(0, 1, 1, enc_jal(5'd1, 21'h40), 1, 32'h2000, 1, 32'h2000, 1);
    fetch(enc_jalr(5'd0, 5'd5));
    upd(32'h2000, 0);
    flush(32'h2000);
    fetch(enc_b(13'h40));
    repeat (8) upd(32'h300, 1);
    upd(32'h300, 0);
    flush(32'h300);
    fetch(enc_b(13'h20));
    repeat (8) upd(32'h304, 0);
    upd(32'h304, 1);
    flush(32'h304);
    fetch(enc_b(13'h20));
    step(0, 0, 1, 32'h13, 0, 0, 1, 32'h308, 0);
    step(0, 0, 1, enc_jal(5'd0, 21'h80), 0, 0, 0, 0, 0);
    fetch(enc_b(13'h10));
    step(0, 0, 0, 0, 1, 32'h500, 0, 0, 0);
    upd(32'h0, 0);
    upd(32'h0, 0);
    step(1, 1, 1, 32'h13, 1, 32'h700, 1, 32'h0, 0);
    fetch(enc_b(13'h40));
    for (int i = 0; i < 600; i++) begin
      rv = $urandom;
      case ($urandom_range(0, 5))
        0: in = 32'h13;
        1: in = enc_b({rv[12:1], 1'b0});
        2: in = enc_jal(rds[$urandom_range(0, 3)], {rv[20:1], 1'b0});
        3: in = enc_jalr(5'd0, $urandom_range(0, 1) ? 5'd1 : 5'd5);
        4: in = enc_jalr(rv[11:7], rv[19:15]);
        default: in = $urandom;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, in,
           $urandom_range(0, 19) == 0, 32'($urandom_range(0, 63)) << 2,
           $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)) << 2, $urandom_range(0, 1) == 1);
    end
    repeat (3) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
